// File: rtl/keypad_entry.sv
// Keypad entry: synchronises the key code stream, records one event per press into a BCD buffer and converts it to binary on confirm.
// Optional range check on confirmed values is enabled by defining KEYPAD_LIMIT_EN.
module keypad_entry #(
    parameter int DIGITS    = 3,
    parameter int VAL_W     = 10,
    parameter int MAX_VALUE = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [2:0]            entry_cnt,
    output logic [VAL_W-1:0]      value_out,
    output logic                  value_valid,
    output logic                  start_pulse,
    output logic                  err_pulse,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 7) begin : g_bad_digits
        $error("keypad_entry: DIGITS must be 1..7");
    end
    if (VAL_W < $clog2(10 ** DIGITS)) begin : g_bad_width
        $error("keypad_entry: VAL_W too narrow for DIGITS");
    end
    if (MAX_VALUE < 0) begin : g_bad_max
        $error("keypad_entry: MAX_VALUE must be non-negative");
    end

    typedef enum logic [1:0] {IDLE, WAIT_REL, CONV, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        key_m_q, key_s_q;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [VAL_W-1:0]  acc_q, acc_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic [3:0]        digit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_m_q <= 4'hF;
            key_s_q <= 4'hF;
        end else begin
            key_m_q <= key_code;
            key_s_q <= key_m_q;
        end
    end

    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) digit = bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s_q != 4'hF) begin
                    state_d = WAIT_REL;
                    if (key_s_q <= 4'd9) begin
                        if (cnt_q < 3'(DIGITS)) begin
                            bcd_d = BW'({bcd_q, key_s_q});
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_s_q)
                            4'hA: start_d = 1'b1;
                            4'hB: begin
                                bcd_d = '0;
                                cnt_d = '0;
                            end
                            4'hC: begin
                                if (cnt_q == 3'd0) begin
                                    err_d = 1'b1;
                                end else begin
                                    state_d = CONV;
                                    acc_d   = '0;
                                    idx_d   = 3'(DIGITS - 1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WAIT_REL: begin
                if (key_s_q == 4'hF) state_d = IDLE;
            end
            CONV: begin
                // Unused upper digits are zero, so scanning all DIGITS positions is safe.
                acc_d = acc_q * VAL_W'(10) + VAL_W'(digit);
                if (idx_q == 3'd0) state_d = DONE;
                else               idx_d   = idx_q - 3'd1;
            end
            DONE: begin
`ifdef KEYPAD_LIMIT_EN
                if (int'(acc_q) > MAX_VALUE) begin
                    err_d = 1'b1;
                end else begin
                    value_d = acc_q;
                    valid_d = 1'b1;
                end
`else
                value_d = acc_q;
                valid_d = 1'b1;
`endif
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = WAIT_REL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign entry_bcd   = bcd_q;
    assign entry_cnt   = cnt_q;
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign start_pulse = start_q;
    assign err_pulse   = err_q;
    assign busy        = (state_q == CONV) || (state_q == DONE);

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: presses push expected output events, a negedge monitor pops and compares them.
module tb_keypad_entry;

    localparam int D   = 3;
    localparam int LAT = 3;
    localparam int CLAT = D + 4;

    logic        clk;
    logic        reset;
    logic [3:0]  key_code;
    logic [11:0] entry_bcd;
    logic [2:0]  entry_cnt;
    logic [9:0]  value_out;
    logic        value_valid, start_pulse, err_pulse, busy;

    keypad_entry #(.DIGITS(D), .VAL_W(10), .MAX_VALUE(500)) dut (
        .clk(clk), .reset(reset), .key_code(key_code),
        .entry_bcd(entry_bcd), .entry_cnt(entry_cnt), .value_out(value_out),
        .value_valid(value_valid), .start_pulse(start_pulse),
        .err_pulse(err_pulse), .busy(busy)
    );

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  cnt;
        logic [9:0]  val;
        logic        vv, sp, ep;
        int          cyc;
        int          id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_id = 0;
    logic [11:0] prev_bcd = '0;
    logic [2:0]  prev_cnt = '0;

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_bcd = entry_bcd;
            prev_cnt = entry_cnt;
        end else begin
            if (value_valid || start_pulse || err_pulse ||
                entry_bcd != prev_bcd || entry_cnt != prev_cnt) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got bcd=%h cnt=%0d val=%0d vv=%b sp=%b ep=%b at cyc=%0d, expected no event",
                             entry_bcd, entry_cnt, value_out, value_valid, start_pulse, err_pulse, cyc);
                end else begin
                    e = q.pop_front();
                    if (entry_bcd !== e.bcd || entry_cnt !== e.cnt || value_out !== e.val ||
                        value_valid !== e.vv || start_pulse !== e.sp || err_pulse !== e.ep || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL ev%0d: got bcd=%h cnt=%0d val=%0d vv=%b sp=%b ep=%b cyc=%0d, expected bcd=%h cnt=%0d val=%0d vv=%b sp=%b ep=%b cyc=%0d",
                                 e.id, entry_bcd, entry_cnt, value_out, value_valid, start_pulse, err_pulse, cyc,
                                 e.bcd, e.cnt, e.val, e.vv, e.sp, e.ep, e.cyc);
                    end
                end
            end
            prev_bcd = entry_bcd;
            prev_cnt = entry_cnt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [11:0] bcd, input logic [2:0] cnt, input logic [9:0] val,
                             input logic vv, input logic sp, input logic ep, input int lat);
        exp_t e;
        e.bcd = bcd; e.cnt = cnt; e.val = val;
        e.vv = vv; e.sp = sp; e.ep = ep;
        e.cyc = cyc + lat;
        e.id = next_id++;
        q.push_back(e);
    endtask

    // One press: key held for 'hold' cycles then released; ev=0 means no output change expected.
    task automatic press(input logic [3:0] k, input bit ev, input logic [11:0] bcd, input logic [2:0] cnt,
                         input logic [9:0] val, input logic vv, input logic sp, input logic ep,
                         input int lat, input int hold);
        @(negedge clk);
        key_code = k;
        if (ev) expect_ev(bcd, cnt, val, vv, sp, ep, lat);
        repeat (hold) @(negedge clk);
        key_code = 4'hF;
        repeat (8) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] k, input logic [11:0] bcd, input logic [2:0] cnt, input logic [9:0] val);
        press(k, 1'b1, bcd, cnt, val, 1'b0, 1'b0, 1'b0, LAT, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        key_code = 4'h5;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(entry_bcd), 0);
        chk("rst_cnt", 32'(entry_cnt), 0);
        chk("rst_val", 32'(value_out), 0);
        chk("rst_pulses", {29'd0, value_valid, start_pulse, err_pulse}, 0);
        chk("rst_busy", 32'(busy), 0);

        // Key already held at reset release: accepted once key_s settles.
        @(negedge clk);
        reset = 1'b1;
        expect_ev(12'h005, 3'd1, 10'd0, 1'b0, 1'b0, 1'b0, LAT);
        repeat (2) @(negedge clk);
        key_code = 4'hF;
        repeat (8) @(negedge clk);

        press(4'hB, 1'b1, 12'h000, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, LAT, 2);
        digit(4'h1, 12'h001, 3'd1, 10'd0);
        digit(4'h2, 12'h012, 3'd2, 10'd0);
        digit(4'h3, 12'h123, 3'd3, 10'd0);
        chk("buf_123", 32'(entry_bcd), 32'h123);

        @(negedge clk);
        key_code = 4'hC;
        expect_ev(12'h000, 3'd0, 10'd123, 1'b1, 1'b0, 1'b0, CLAT);
        repeat (3) @(negedge clk);
        chk("busy_conv", 32'(busy), 1);
        key_code = 4'hF;
        repeat (4) @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        repeat (8) @(negedge clk);

        press(4'h7, 1'b1, 12'h007, 3'd1, 10'd123, 1'b0, 1'b0, 1'b0, LAT, 50);
        digit(4'h7, 12'h077, 3'd2, 10'd123);

        press(4'hB, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b0, LAT, 2);
        digit(4'h9, 12'h009, 3'd1, 10'd123);
        digit(4'h8, 12'h098, 3'd2, 10'd123);
        digit(4'h7, 12'h987, 3'd3, 10'd123);
        press(4'h6, 1'b1, 12'h987, 3'd3, 10'd123, 1'b0, 1'b0, 1'b1, LAT, 2);

        press(4'hB, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b0, LAT, 2);
        press(4'hC, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b1, LAT, 2);
        digit(4'h4, 12'h004, 3'd1, 10'd123);
        digit(4'h2, 12'h042, 3'd2, 10'd123);
        press(4'hB, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b0, LAT, 2);

        digit(4'h5, 12'h005, 3'd1, 10'd123);
        press(4'hA, 1'b1, 12'h005, 3'd1, 10'd123, 1'b0, 1'b1, 1'b0, LAT, 2);
        press(4'hD, 1'b0, 12'h000, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, LAT, 2);
        press(4'hE, 1'b0, 12'h000, 3'd0, 10'd0, 1'b0, 1'b0, 1'b0, LAT, 2);
        press(4'hB, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b0, LAT, 2);

        digit(4'h6, 12'h006, 3'd1, 10'd123);
        digit(4'h0, 12'h060, 3'd2, 10'd123);
        digit(4'h0, 12'h600, 3'd3, 10'd123);
`ifdef KEYPAD_LIMIT_EN
        press(4'hC, 1'b1, 12'h000, 3'd0, 10'd123, 1'b0, 1'b0, 1'b1, CLAT, 4);
`else
        press(4'hC, 1'b1, 12'h000, 3'd0, 10'd600, 1'b1, 1'b0, 1'b0, CLAT, 4);
`endif
        digit(4'h4, 12'h004, 3'd1, value_out);
        digit(4'h9, 12'h049, 3'd2, value_out);
        digit(4'h9, 12'h499, 3'd3, value_out);
        press(4'hC, 1'b1, 12'h000, 3'd0, 10'd499, 1'b1, 1'b0, 1'b0, CLAT, 4);
        chk("val_499", 32'(value_out), 499);

        digit(4'h4, 12'h004, 3'd1, 10'd499);
        digit(4'h5, 12'h045, 3'd2, 10'd499);
        @(negedge clk);
        key_code = 4'hC;
        repeat (4) @(negedge clk);
        chk("busy_pre_abort", 32'(busy), 1);
        #2 reset = 1'b0;
        key_code = 4'hF;
        #1;
        chk("abort_val", 32'(value_out), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bcd", 32'(entry_bcd), 0);
        chk("abort_pulses", {29'd0, value_valid, start_pulse, err_pulse}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_val_held", 32'(value_out), 0);

        chk("pending_events", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
